// File: rtl/iq_detector.sv
// Quadrature demodulator: accumulates x*cos and x*sin over a programmed sample count and
// presents the sums through a valid/ready handshake.
module iq_detector #(
    parameter int unsigned ADC_WIDTH    = 12,
    parameter int unsigned REF_WIDTH    = 14,
    parameter int unsigned ACC_WIDTH    = 48,
    parameter int unsigned MAX_LEN_LOG2 = 20
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [ADC_WIDTH-1:0]        adc_data,
    input  logic                        adc_valid,
    input  logic signed [REF_WIDTH-1:0] ref_cos,
    input  logic signed [REF_WIDTH-1:0] ref_sin,
    input  logic                        param_wen,
    input  logic [31:0]                 acc_len,
    input  logic                        start,
    output logic                        busy,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic signed [ACC_WIDTH-1:0] res_i,
    output logic signed [ACC_WIDTH-1:0] res_q,
    output logic [31:0]                 res_count,
    output logic                        overflow
);

    localparam int unsigned PROD_WIDTH = ADC_WIDTH + REF_WIDTH;
    localparam int unsigned LEN_WIDTH  = MAX_LEN_LOG2 + 1;
    localparam logic [31:0] MAX_LEN    = 32'(1) << MAX_LEN_LOG2;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                         state;
    logic [LEN_WIDTH-1:0]           len_buf;
    logic [LEN_WIDTH-1:0]           len_req;
    logic [LEN_WIDTH-1:0]           issued;
    logic [LEN_WIDTH-1:0]           issued_inc;
    logic                           accept;

    logic                           s0_valid;
    logic signed [ADC_WIDTH-1:0]    s0_x;
    logic signed [REF_WIDTH-1:0]    s0_cos;
    logic signed [REF_WIDTH-1:0]    s0_sin;
    logic                           s1_valid;
    logic signed [PROD_WIDTH-1:0]   prod_i;
    logic signed [PROD_WIDTH-1:0]   prod_q;
    logic signed [ACC_WIDTH-1:0]    acc_i;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [ACC_WIDTH-1:0]    ext_i;
    logic signed [ACC_WIDTH-1:0]    ext_q;
    logic signed [ACC_WIDTH-1:0]    sum_i;
    logic signed [ACC_WIDTH-1:0]    sum_q;
    logic                           ovf_i;
    logic                           ovf_q;

    // Zero-length requests still take one sample; oversized requests saturate.
    always_comb begin
        if (acc_len == 32'd0) begin
            len_req = LEN_WIDTH'(1);
        end else if (acc_len > MAX_LEN) begin
            len_req = MAX_LEN[LEN_WIDTH-1:0];
        end else begin
            len_req = acc_len[LEN_WIDTH-1:0];
        end
    end

    assign accept     = (state == StRun) && adc_valid;
    assign issued_inc = issued + LEN_WIDTH'(1);

    assign ext_i = {{(ACC_WIDTH-PROD_WIDTH){prod_i[PROD_WIDTH-1]}}, prod_i};
    assign ext_q = {{(ACC_WIDTH-PROD_WIDTH){prod_q[PROD_WIDTH-1]}}, prod_q};
    assign sum_i = acc_i + ext_i;
    assign sum_q = acc_q + ext_q;
    assign ovf_i = (acc_i[ACC_WIDTH-1] == ext_i[ACC_WIDTH-1]) &&
                   (sum_i[ACC_WIDTH-1] != acc_i[ACC_WIDTH-1]);
    assign ovf_q = (acc_q[ACC_WIDTH-1] == ext_q[ACC_WIDTH-1]) &&
                   (sum_q[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= StIdle;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            overflow  <= 1'b0;
            res_i     <= '0;
            res_q     <= '0;
            res_count <= '0;
            len_buf   <= LEN_WIDTH'(1);
            issued    <= '0;
            s0_valid  <= 1'b0;
            s0_x      <= '0;
            s0_cos    <= '0;
            s0_sin    <= '0;
            s1_valid  <= 1'b0;
            prod_i    <= '0;
            prod_q    <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
        end else begin
            // Offset-binary to two's complement is an MSB flip.
            s0_valid <= accept;
            if (accept) begin
                s0_x   <= {~adc_data[ADC_WIDTH-1], adc_data[ADC_WIDTH-2:0]};
                s0_cos <= ref_cos;
                s0_sin <= ref_sin;
            end

            s1_valid <= s0_valid;
            if (s0_valid) begin
                prod_i <= PROD_WIDTH'(s0_x) * PROD_WIDTH'(s0_cos);
                prod_q <= PROD_WIDTH'(s0_x) * PROD_WIDTH'(s0_sin);
            end

            if (s1_valid) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                if (ovf_i || ovf_q) begin
                    overflow <= 1'b1;
                end
            end

            unique case (state)
                StIdle: begin
                    if (param_wen) begin
                        len_buf <= len_req;
                    end
                    if (start) begin
                        acc_i    <= '0;
                        acc_q    <= '0;
                        issued   <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= StRun;
                    end
                end
                StRun: begin
                    if (adc_valid) begin
                        issued <= issued_inc;
                        if (issued_inc == len_buf) begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // Pipeline empty means the final product has reached the accumulator.
                    if (!s0_valid && !s1_valid) begin
                        res_i     <= acc_i;
                        res_q     <= acc_q;
                        res_count <= 32'(issued);
                        res_valid <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_detector.sv
// Self-checking bench for iq_detector: randomized samples compared with an arithmetic
// reference sum, plus the directed DC, gap, back-pressure, length and reset scenarios.
module tb_iq_detector;

    localparam int ADC_W = 12;
    localparam int REF_W = 14;
    localparam int ACC_W = 48;
    localparam int LOG2  = 12;
    localparam int MAXL  = 1 << LOG2;
    localparam longint MID = longint'(1) << (ADC_W - 1);

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic [ADC_W-1:0]        adc_data = '0;
    logic                    adc_valid = 1'b0;
    logic signed [REF_W-1:0] ref_cos = '0;
    logic signed [REF_W-1:0] ref_sin = '0;
    logic                    param_wen = 1'b0;
    logic [31:0]             acc_len = '0;
    logic                    start = 1'b0;
    logic                    busy;
    logic                    res_valid;
    logic                    res_ready = 1'b0;
    logic signed [ACC_W-1:0] res_i;
    logic signed [ACC_W-1:0] res_q;
    logic [31:0]             res_count;
    logic                    overflow;

    int checks = 0;
    int errors = 0;
    int cur_len = 1;

    logic [ADC_W-1:0] smp_adc [MAXL];
    logic [REF_W-1:0] smp_cos [MAXL];
    logic [REF_W-1:0] smp_sin [MAXL];

    always #5 clk = ~clk;

    iq_detector #(
        .ADC_WIDTH   (ADC_W),
        .REF_WIDTH   (REF_W),
        .ACC_WIDTH   (ACC_W),
        .MAX_LEN_LOG2(LOG2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .adc_data (adc_data),
        .adc_valid(adc_valid),
        .ref_cos  (ref_cos),
        .ref_sin  (ref_sin),
        .param_wen(param_wen),
        .acc_len  (acc_len),
        .start    (start),
        .busy     (busy),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_i    (res_i),
        .res_q    (res_q),
        .res_count(res_count),
        .overflow (overflow)
    );

    function automatic int model_len(input logic [31:0] l);
        if (l == 32'd0) return 1;
        if (longint'(l) > longint'(MAXL)) return MAXL;
        return int'(l);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < MAXL; i++) begin
            smp_adc[i] = ADC_W'($urandom);
            smp_cos[i] = REF_W'($urandom);
            smp_sin[i] = REF_W'($urandom);
        end
    endtask

    task automatic fill_fixed(input logic [ADC_W-1:0] a, input logic [REF_W-1:0] c,
                              input logic [REF_W-1:0] s);
        for (int i = 0; i < MAXL; i++) begin
            smp_adc[i] = a;
            smp_cos[i] = c;
            smp_sin[i] = s;
        end
    endtask

    // One full measurement; param_wen and start share a cycle when prog is set.
    task automatic measure(input string name, input logic [31:0] len, input bit prog,
                           input bit gapped, input int hold, input bit disturb);
        longint exp_i = 0;
        longint exp_q = 0;
        longint x, c, s;
        logic [ACC_W-1:0] ei, eq;
        int n = 0;
        int cyc = 0;
        int lat = 0;
        if (prog) cur_len = model_len(len);
        @(negedge clk);
        param_wen = prog;
        acc_len   = len;
        start     = 1'b1;
        @(negedge clk);
        param_wen = 1'b0;
        start     = 1'b0;
        while (n < cur_len && cyc < 2 * MAXL + 16) begin
            adc_valid = gapped ? ((cyc % 2) == 0) : 1'b1;
            res_ready = 1'($urandom_range(0, 1));
            if (adc_valid) begin
                adc_data = smp_adc[n];
                ref_cos  = smp_cos[n];
                ref_sin  = smp_sin[n];
                x = longint'(smp_adc[n]) - MID;
                c = longint'($signed(smp_cos[n]));
                s = longint'($signed(smp_sin[n]));
                exp_i += x * c;
                exp_q += x * s;
                n++;
            end else begin
                adc_data = ADC_W'($urandom);
                ref_cos  = REF_W'($urandom);
                ref_sin  = REF_W'($urandom);
            end
            @(negedge clk);
            cyc++;
            if (gapped) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_gap: got %b expected 1 at cycle %0d", name, busy, cyc);
                end
            end
        end
        ei = exp_i[ACC_W-1:0];
        eq = exp_q[ACC_W-1:0];
        res_ready = 1'b0;
        // Keep offering samples during drain; they must be ignored.
        while (res_valid !== 1'b1 && lat < 8) begin
            adc_valid = 1'b1;
            adc_data  = ADC_W'($urandom);
            ref_cos   = REF_W'($urandom);
            ref_sin   = REF_W'($urandom);
            @(negedge clk);
            lat++;
        end
        adc_valid = 1'b0;
        checks++;
        if (lat != 3 || n != cur_len) begin
            errors++;
            $display("FAIL %s latency: got %0d edges (%0d samples) expected 3 (%0d)",
                     name, lat, n, cur_len);
        end
        checks++;
        if (res_i !== ei) begin
            errors++;
            $display("FAIL %s res_i: got %0d expected %0d", name, res_i, $signed(ei));
        end
        checks++;
        if (res_q !== eq) begin
            errors++;
            $display("FAIL %s res_q: got %0d expected %0d", name, res_q, $signed(eq));
        end
        checks++;
        if (res_count !== 32'(cur_len)) begin
            errors++;
            $display("FAIL %s res_count: got %0d expected %0d", name, res_count, cur_len);
        end
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s flags: got ovf=%b busy=%b expected 0 1", name, overflow, busy);
        end
        for (int k = 0; k < hold; k++) begin
            start     = disturb && (k == 2);
            param_wen = disturb && (k == 2);
            acc_len   = 32'd3;
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_i !== ei || res_q !== eq ||
                res_count !== 32'(cur_len)) begin
                errors++;
                $display("FAIL %s hold%0d: got v=%b i=%0d q=%0d n=%0d expected 1 %0d %0d %0d",
                         name, k, res_valid, res_i, res_q, res_count,
                         $signed(ei), $signed(eq), cur_len);
            end
        end
        start     = 1'b0;
        param_wen = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: got valid=%b busy=%b expected 0 0", name, res_valid, busy);
        end
        checks++;
        if (res_i !== ei || res_q !== eq) begin
            errors++;
            $display("FAIL %s retained: got %0d %0d expected %0d %0d",
                     name, res_i, res_q, $signed(ei), $signed(eq));
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || overflow !== 1'b0 || res_i !== '0 ||
            res_q !== '0 || res_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got b=%b v=%b o=%b i=%0d q=%0d n=%0d expected all 0",
                     busy, res_valid, overflow, res_i, res_q, res_count);
        end
        rstn = 1'b1;
        cur_len = 1;
    endtask

    task automatic test_default_len();
        fill_random();
        measure("default_len", 32'd77, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_dc();
        fill_fixed(12'hFFF, 14'sd8191, 14'sd0);
        measure("dc", 32'd4, 1'b1, 1'b0, 0, 1'b0);
        checks++;
        if (res_i !== 48'sd67067908 || res_q !== 48'sd0) begin
            errors++;
            $display("FAIL dc_const: got %0d %0d expected 67067908 0", res_i, res_q);
        end
    endtask

    task automatic test_mid_neg();
        fill_fixed(12'h800, REF_W'($urandom), REF_W'($urandom));
        measure("midscale", 32'd3, 1'b1, 1'b0, 0, 1'b0);
        checks++;
        if (res_i !== '0 || res_q !== '0) begin
            errors++;
            $display("FAIL midscale_const: got %0d %0d expected 0 0", res_i, res_q);
        end
        fill_fixed(12'h000, 14'sd0, -14'sd8192);
        measure("negative", 32'd2, 1'b1, 1'b0, 0, 1'b0);
        checks++;
        if (res_i !== '0 || res_q !== 48'sd33554432) begin
            errors++;
            $display("FAIL negative_const: got %0d %0d expected 0 33554432", res_i, res_q);
        end
    endtask

    task automatic test_gapped();
        fill_random();
        measure("ungapped", 32'd8, 1'b1, 1'b0, 0, 1'b0);
        measure("gapped", 32'd8, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_back_pressure();
        fill_random();
        measure("backpressure", 32'd5, 1'b1, 1'b0, 10, 1'b1);
        // The param_wen issued during the hold must not have changed the length.
        fill_random();
        measure("after_hold", 32'd9, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            fill_random();
            measure("random", 32'($urandom_range(1, 40)), 1'b1, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_edge_lengths();
        fill_random();
        measure("len_zero", 32'd0, 1'b1, 1'b0, 0, 1'b0);
        fill_random();
        measure("len_max", 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0);
        checks++;
        if (res_count !== 32'(MAXL)) begin
            errors++;
            $display("FAIL len_max_const: got %0d expected %0d", res_count, MAXL);
        end
    endtask

    task automatic test_reset_mid_run();
        fill_random();
        @(negedge clk);
        param_wen = 1'b1;
        acc_len   = 32'd10;
        start     = 1'b1;
        @(negedge clk);
        param_wen = 1'b0;
        start     = 1'b0;
        for (int k = 0; k < 5; k++) begin
            adc_valid = 1'b1;
            adc_data  = ADC_W'($urandom);
            ref_cos   = REF_W'($urandom);
            ref_sin   = REF_W'($urandom);
            @(negedge clk);
        end
        adc_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || overflow !== 1'b0 || res_i !== '0 ||
            res_q !== '0 || res_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_run: got b=%b v=%b o=%b i=%0d q=%0d n=%0d expected all 0",
                     busy, res_valid, overflow, res_i, res_q, res_count);
        end
        rstn = 1'b1;
        cur_len = 1;
        fill_random();
        measure("fresh_after_reset", 32'd2, 1'b1, 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_default_len();
        test_dc();
        test_mid_neg();
        test_gapped();
        test_back_pressure();
        test_random();
        test_edge_lengths();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
